pwm_mask_event_ctrl: RTL and testbench
======================================

// Module: pwm_mask_event_ctrl
// PURPOSE
//  Sequences the shadow-register update strobe (maskevent) for all PWM compare/period
//  shadow registers of one PWM channel group. Turns carrier-counter events (zero, period)
//  into qualified update slots, decimated by a programmable skip count, and commits
//  software update requests through a req/ack handshake. Sits between the AXI4-Lite
//  register bank and the register_mask_16bits instances of the carrier datapath.
// PARAMETERS
//  SKIP_WIDTH   4  width of mask_skip and the internal slot counter
//  AUTO_UPDATE  0  1: maskevent on every slot; 0: maskevent only on slots with a pending request
// PORTS
//  clk          in   1           system clock; all logic on posedge
//  reset_n      in   1           asynchronous, active-low reset
//  pwm_onoff    in   _pwm_onoff  PWM_ON / PWM_OFF run state from the control register
//  mask_mode    in   _mask_mode  slot source: MASK_NONE, MASK_ZERO, MASK_PERIOD, MASK_BOTH
//  mask_skip    in   SKIP_WIDTH  qualifying events skipped between slots (0 = every event)
//  evt_zero     in   1           1-cycle pulse: carrier counter at 0
//  evt_period   in   1           1-cycle pulse: carrier counter at period
//  upd_req      in   1           1-cycle pulse: software wrote new shadow values
//  force_upd    in   1           1-cycle pulse: commit immediately, ignore slots
//  maskevent    out  1           1-cycle strobe to all shadow registers
//  upd_pending  out  1           request accepted, awaiting commit
//  upd_ack      out  1           1-cycle pulse: pending request committed
//  slot_cnt     out  SKIP_WIDTH  current slot-counter value (status readback)
// BEHAVIOUR
//  - Reset (reset_n=0, async): maskevent=0, upd_pending=0, upd_ack=0, slot_cnt=0, FSM=OFF.
//  - Qualifying event q: ZERO->evt_zero; PERIOD->evt_period; BOTH->evt_zero|evt_period
//    (coincident pulses count once); NONE->never.
//  - FSM states OFF, RUN:
//    OFF (pwm_onoff==PWM_OFF): shadows are transparent; maskevent=0; slot_cnt held at 0;
//      upd_req -> upd_ack pulse next cycle, upd_pending stays 0. OFF->RUN on PWM_ON,
//      slot_cnt loaded with mask_skip on the transition cycle.
//    RUN: on q: slot_cnt==0 -> slot; reload slot_cnt=mask_skip; else slot_cnt-=1.
//      RUN->OFF on PWM_OFF: if upd_pending, clear it and pulse upd_ack next cycle.
//  - Slot commit: maskevent=1 in cycle n+1 for a slot at cycle n when
//    AUTO_UPDATE=1 or upd_pending==1 at cycle n. If upd_pending, also upd_ack=1 and
//    upd_pending=0 in cycle n+1. Latency event->strobe: exactly 1 cycle.
//  - upd_req: sets upd_pending in cycle n+1 (RUN). upd_req coincident with a slot is NOT
//    served by that slot (pending is registered); served at next slot. upd_req while
//    pending: coalesced, no second ack.
//  - force_upd (RUN): maskevent=1 next cycle; if pending, upd_ack=1 and pending cleared;
//    slot_cnt unaffected. force_upd + slot same cycle: one maskevent, one ack. force_upd
//    + upd_req same cycle: commit issued, request stays pending for next slot.
//  - mask_skip change mid-run: takes effect at next reload only. slot_cnt never wraps below 0.
//  - MASK_NONE in RUN: only force_upd produces maskevent; pending waits indefinitely.
//  - mask_mode change: applies from the next cycle; slot_cnt not reset.
// STRUCTURE
//  - PKG_pwm: existing _pwm_onoff/PWM_ON/PWM_OFF; add typedef enum logic [1:0] _mask_mode
//    {MASK_NONE=0, MASK_ZERO=1, MASK_PERIOD=2, MASK_BOTH=3}; add _mask_fsm {MFSM_OFF, MFSM_RUN}.
//  - Sub-module pwm_slot_counter: q input, mask_skip load, slot output, slot_cnt status.
//  - FSM, pending flag and output registers in the top module; all outputs registered.
// TESTING
//  1 Reset: assert reset_n=0 mid-commit -> maskevent/upd_ack/upd_pending/slot_cnt=0 asynchronously.
//  2 RUN, ZERO, skip=2, AUTO_UPDATE=1, evt_zero every 100 cycles -> maskevent on 1st,4th,7th
//    events, each 1 cycle after the event; slot_cnt reads 2,1,0,2 sequence.
//  3 AUTO_UPDATE=0, BOTH, skip=0: upd_req at cycle 10, evt_period at 50 -> maskevent+upd_ack
//    at 51, pending 11..51; evt_zero+evt_period coincident -> single decrement/slot.
//  4 upd_req in same cycle as slot -> no maskevent at that slot; committed at next slot;
//    three upd_req before slot -> one upd_ack.
//  5 force_upd with pending, mode NONE -> maskevent+upd_ack next cycle; force_upd+slot same
//    cycle -> exactly one maskevent and one ack.
//  6 PWM_OFF with pending -> pending clears, upd_ack 1 cycle later, no maskevent; OFF upd_req
//    -> immediate ack; OFF->ON reloads slot_cnt=mask_skip.

Source files
------------

// File: rtl/pwm_mask_event_ctrl_pkg.sv
// Shared PWM types: run state, mask slot source and mask-event FSM encoding,
// plus the helper that turns carrier events into a qualifying event.
package PKG_pwm;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  typedef enum logic [1:0] {
    MASK_NONE   = 2'd0,
    MASK_ZERO   = 2'd1,
    MASK_PERIOD = 2'd2,
    MASK_BOTH   = 2'd3
  } _mask_mode;

  typedef enum logic {
    MFSM_OFF = 1'b0,
    MFSM_RUN = 1'b1
  } _mask_fsm;

  // Coincident zero/period pulses in MASK_BOTH collapse into one event.
  function automatic logic mask_qualify(input _mask_mode mode,
                                        input logic      ev_zero,
                                        input logic      ev_period);
    logic q;
    q = 1'b0;
    case (mode)
      MASK_ZERO:   q = ev_zero;
      MASK_PERIOD: q = ev_period;
      MASK_BOTH:   q = ev_zero | ev_period;
      default:     q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/pwm_mask_event_ctrl_slot_counter.sv
// Decimating slot counter: a slot is a qualifying event seen while the count is 0;
// each slot reloads mask_skip, other events count down without wrapping.
import PKG_pwm::*;

module pwm_slot_counter #(
  parameter int SKIP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  load,
  input  logic                  q,
  input  logic [SKIP_WIDTH-1:0] mask_skip,
  output logic                  slot,
  output logic [SKIP_WIDTH-1:0] slot_cnt
);

  assign slot = run & q & (slot_cnt == '0);

  // mask_skip is sampled only on load or reload, so mid-run changes wait for the next slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt <= '0;
    end else if (load) begin
      slot_cnt <= mask_skip;
    end else if (!run) begin
      slot_cnt <= '0;
    end else if (q) begin
      if (slot_cnt == '0) slot_cnt <= mask_skip;
      else                slot_cnt <= slot_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pwm_mask_event_ctrl.sv
// Shadow-register update sequencer: turns qualified carrier slots and software
// requests into a single registered maskevent strobe with req/ack bookkeeping.
import PKG_pwm::*;

module pwm_mask_event_ctrl #(
  parameter int SKIP_WIDTH  = 4,
  parameter int AUTO_UPDATE = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  _pwm_onoff             pwm_onoff,
  input  _mask_mode             mask_mode,
  input  logic [SKIP_WIDTH-1:0] mask_skip,
  input  logic                  evt_zero,
  input  logic                  evt_period,
  input  logic                  upd_req,
  input  logic                  force_upd,
  output logic                  maskevent,
  output logic                  upd_pending,
  output logic                  upd_ack,
  output logic [SKIP_WIDTH-1:0] slot_cnt,
  output _mask_fsm              fsm_state
);

  // Handshake: upd_req is a one-cycle request; upd_pending holds it until a commit,
  // and upd_ack pulses for exactly one cycle when that held request is retired.

  localparam logic AUTO_ON = (AUTO_UPDATE != 0);

  _mask_fsm state;
  logic     q;
  logic     slot;
  logic     run_active;
  logic     load;
  logic     commit;

  assign q          = mask_qualify(mask_mode, evt_zero, evt_period);
  assign run_active = (state == MFSM_RUN) && (pwm_onoff == PWM_ON);
  assign load       = (state == MFSM_OFF) && (pwm_onoff == PWM_ON);
  assign commit     = run_active & (force_upd | (slot & (AUTO_ON | upd_pending)));
  assign fsm_state  = state;

  pwm_slot_counter #(
    .SKIP_WIDTH(SKIP_WIDTH)
  ) u_slot_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run_active),
    .load      (load),
    .q         (q),
    .mask_skip (mask_skip),
    .slot      (slot),
    .slot_cnt  (slot_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= MFSM_OFF;
      maskevent   <= 1'b0;
      upd_pending <= 1'b0;
      upd_ack     <= 1'b0;
    end else begin
      case (state)
        MFSM_OFF: begin
          // Shadows are transparent while off, so a request is acknowledged at once.
          maskevent   <= 1'b0;
          upd_pending <= 1'b0;
          upd_ack     <= upd_req;
          if (pwm_onoff == PWM_ON) state <= MFSM_RUN;
        end
        MFSM_RUN: begin
          if (pwm_onoff == PWM_OFF) begin
            state       <= MFSM_OFF;
            maskevent   <= 1'b0;
            upd_ack     <= upd_pending | upd_req;
            upd_pending <= 1'b0;
          end else begin
            // A request arriving with a commit is not covered by it and stays pending.
            maskevent   <= commit;
            upd_ack     <= commit & upd_pending;
            upd_pending <= upd_req | (upd_pending & ~commit);
          end
        end
        default: begin
          state       <= MFSM_OFF;
          maskevent   <= 1'b0;
          upd_pending <= 1'b0;
          upd_ack     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_mask_event_ctrl.sv
// Directed bench for pwm_mask_event_ctrl: one instance with AUTO_UPDATE=1 and one
// with AUTO_UPDATE=0 share all inputs; expected values are hand-derived per step.
import PKG_pwm::*;

module tb_pwm_mask_event_ctrl;

  logic       clk;
  logic       reset_n;
  _pwm_onoff  pwm_onoff;
  _mask_mode  mask_mode;
  logic [3:0] mask_skip;
  logic       evt_zero;
  logic       evt_period;
  logic       upd_req;
  logic       force_upd;

  logic       a_me, a_pend, a_ack;
  logic [3:0] a_cnt;
  _mask_fsm   a_st;
  logic       m_me, m_pend, m_ack;
  logic [3:0] m_cnt;
  _mask_fsm   m_st;

  int total;
  int bad;

  logic [3:0] cnt_tbl [7];

  pwm_mask_event_ctrl #(.SKIP_WIDTH(4), .AUTO_UPDATE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .pwm_onoff(pwm_onoff), .mask_mode(mask_mode),
    .mask_skip(mask_skip), .evt_zero(evt_zero), .evt_period(evt_period),
    .upd_req(upd_req), .force_upd(force_upd), .maskevent(a_me),
    .upd_pending(a_pend), .upd_ack(a_ack), .slot_cnt(a_cnt), .fsm_state(a_st)
  );

  pwm_mask_event_ctrl #(.SKIP_WIDTH(4), .AUTO_UPDATE(0)) dut_m (
    .clk(clk), .reset_n(reset_n), .pwm_onoff(pwm_onoff), .mask_mode(mask_mode),
    .mask_skip(mask_skip), .evt_zero(evt_zero), .evt_period(evt_period),
    .upd_req(upd_req), .force_upd(force_upd), .maskevent(m_me),
    .upd_pending(m_pend), .upd_ack(m_ack), .slot_cnt(m_cnt), .fsm_state(m_st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_m(input string tag, input logic me, input logic ack, input logic pend);
    chk({tag, "_m_me"},   8'(m_me),   8'(me));
    chk({tag, "_m_ack"},  8'(m_ack),  8'(ack));
    chk({tag, "_m_pend"}, 8'(m_pend), 8'(pend));
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    cnt_tbl    = '{4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2};
    reset_n    = 1'b0;
    pwm_onoff  = PWM_OFF;
    mask_mode  = MASK_ZERO;
    mask_skip  = 4'd0;
    evt_zero   = 1'b0;
    evt_period = 1'b0;
    upd_req    = 1'b0;
    force_upd  = 1'b0;

    #12;
    chk("rst_me",  8'(a_me),  8'd0);
    chk("rst_pend", 8'(a_pend), 8'd0);
    chk("rst_ack", 8'(a_ack), 8'd0);
    chk("rst_cnt", 8'(a_cnt), 8'd0);
    chk("rst_st",  8'(m_st),  8'(MFSM_OFF));
    tick();
    reset_n = 1'b1;
    tick();

    // Decimation: ON with skip=0 so the first event is a slot, then skip=2 on reload
    pwm_onoff = PWM_ON;
    tick();
    chk("on_st",  8'(a_st),  8'(MFSM_RUN));
    chk("on_cnt", 8'(a_cnt), 8'd0);
    mask_skip = 4'd2;
    for (int k = 0; k < 7; k++) begin
      repeat (99) tick();
      chk("dec_idle_me", 8'(a_me), 8'd0);
      evt_zero = 1'b1;
      tick();
      evt_zero = 1'b0;
      chk("dec_a_me", 8'(a_me), ((k % 3) == 0) ? 8'd1 : 8'd0);
      chk("dec_a_cnt", 8'(a_cnt), 8'(cnt_tbl[k]));
      chk("dec_m_me", 8'(m_me), 8'd0);
    end
    tick();
    chk("dec_after_me", 8'(a_me), 8'd0);

    // Restart with BOTH, skip=0; request at cycle 10, period event at cycle 50
    pwm_onoff = PWM_OFF;
    mask_skip = 4'd0;
    mask_mode = MASK_BOTH;
    tick();
    chk("off_st",  8'(m_st),  8'(MFSM_OFF));
    chk("off_cnt", 8'(m_cnt), 8'd0);
    pwm_onoff = PWM_ON;
    tick();
    chk("on2_cnt", 8'(m_cnt), 8'd0);
    repeat (9) tick();
    upd_req = 1'b1;
    tick();
    upd_req = 1'b0;
    chk_m("req10", 1'b0, 1'b0, 1'b1);
    repeat (39) tick();
    chk_m("req_wait", 1'b0, 1'b0, 1'b1);
    evt_period = 1'b1;
    tick();
    evt_period = 1'b0;
    chk_m("per50", 1'b1, 1'b1, 1'b0);
    chk("per50_a_ack", 8'(a_ack), 8'd1);
    tick();
    chk_m("per51", 1'b0, 1'b0, 1'b0);

    // Coincident zero+period: one decrement, one slot
    mask_skip = 4'd1;
    evt_zero = 1'b1;
    tick();
    evt_zero = 1'b0;
    chk("reload_a_me", 8'(a_me), 8'd1);
    chk("reload_cnt",  8'(a_cnt), 8'd1);
    evt_zero = 1'b1; evt_period = 1'b1;
    tick();
    chk("coin1_a_me", 8'(a_me), 8'd0);
    chk("coin1_cnt",  8'(a_cnt), 8'd0);
    tick();
    evt_zero = 1'b0; evt_period = 1'b0;
    chk("coin2_a_me", 8'(a_me), 8'd1);
    chk("coin2_cnt",  8'(a_cnt), 8'd1);

    // Request coincident with slot is not served; three requests give one ack
    mask_skip = 4'd0;
    evt_zero = 1'b1;
    tick();
    evt_zero = 1'b0;
    chk("pre_cnt", 8'(m_cnt), 8'd0);
    evt_zero = 1'b1; upd_req = 1'b1;
    tick();
    evt_zero = 1'b0; upd_req = 1'b0;
    chk_m("req_slot", 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 2; r++) begin
      upd_req = 1'b1;
      tick();
      upd_req = 1'b0;
      tick();
    end
    chk_m("req_coal", 1'b0, 1'b0, 1'b1);
    evt_period = 1'b1;
    tick();
    evt_period = 1'b0;
    chk_m("coal_slot", 1'b1, 1'b1, 1'b0);
    tick();
    chk_m("coal_after", 1'b0, 1'b0, 1'b0);
    evt_zero = 1'b1;
    tick();
    evt_zero = 1'b0;
    chk_m("coal_noack", 1'b0, 1'b0, 1'b0);

    // Force in MASK_NONE
    mask_mode = MASK_NONE;
    upd_req = 1'b1;
    tick();
    upd_req = 1'b0;
    evt_zero = 1'b1;
    tick();
    evt_zero = 1'b0;
    chk_m("none_evt", 1'b0, 1'b0, 1'b1);
    chk("none_a_me", 8'(a_me), 8'd0);
    force_upd = 1'b1;
    tick();
    force_upd = 1'b0;
    chk_m("none_force", 1'b1, 1'b1, 1'b0);
    chk("none_cnt", 8'(m_cnt), 8'd0);

    // Force coincident with slot: one strobe, one ack
    mask_mode = MASK_ZERO;
    upd_req = 1'b1;
    tick();
    upd_req = 1'b0;
    force_upd = 1'b1; evt_zero = 1'b1;
    tick();
    force_upd = 1'b0; evt_zero = 1'b0;
    chk_m("fslot", 1'b1, 1'b1, 1'b0);
    tick();
    chk_m("fslot_after", 1'b0, 1'b0, 1'b0);

    // Force with a new request: commit issued, request stays pending
    force_upd = 1'b1; upd_req = 1'b1;
    tick();
    force_upd = 1'b0; upd_req = 1'b0;
    chk_m("freq", 1'b1, 1'b0, 1'b1);

    // Turning off with a pending request
    pwm_onoff = PWM_OFF;
    tick();
    chk_m("off_pend", 1'b0, 1'b1, 1'b0);
    chk("off_pend_st", 8'(m_st), 8'(MFSM_OFF));
    tick();
    chk_m("off_after", 1'b0, 1'b0, 1'b0);
    upd_req = 1'b1; evt_zero = 1'b1;
    tick();
    upd_req = 1'b0; evt_zero = 1'b0;
    chk_m("off_req", 1'b0, 1'b1, 1'b0);
    chk("off_a_me", 8'(a_me), 8'd0);
    mask_skip = 4'd3;
    pwm_onoff = PWM_ON;
    tick();
    chk("reon_cnt", 8'(m_cnt), 8'd3);
    chk("reon_st",  8'(m_st),  8'(MFSM_RUN));

    // Asynchronous reset while a commit is visible
    upd_req = 1'b1;
    tick();
    upd_req = 1'b0;
    force_upd = 1'b1;
    tick();
    force_upd = 1'b0;
    chk_m("pre_rst", 1'b1, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_me",   8'(m_me),   8'd0);
    chk("arst_ack",  8'(m_ack),  8'd0);
    chk("arst_pend", 8'(m_pend), 8'd0);
    chk("arst_cnt",  8'(m_cnt),  8'd0);
    chk("arst_st",   8'(a_st),   8'(MFSM_OFF));
    tick();
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
